// File: rtl/memory_access_if.sv
// Execute-to-memory-to-writeback bundle for the memory_access stage.
// slave: the stage itself; master: its surroundings (execute, memory, wb).
interface memory_access_if;
  logic        in_valid;
  logic        in_ready;
  logic        is_load;
  logic        is_store;
  logic [2:0]  func3;
  logic [31:0] addr_result;
  logic [31:0] store_data;
  logic [4:0]  dest_i;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic        misalign;

  modport slave (
    input  in_valid, is_load, is_store, func3,
    input  addr_result, store_data, dest_i,
    input  mem_ready, mem_rdata,
    output in_ready,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output wb_valid, wb_dest, wb_data, misalign
  );

  modport master (
    output in_valid, is_load, is_store, func3,
    output addr_result, store_data, dest_i,
    output mem_ready, mem_rdata,
    input  in_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  wb_valid, wb_dest, wb_data, misalign
  );
endinterface

// File: rtl/memory_access.sv
// Memory-access pipeline stage: loads/stores with ready handshake.
// Optional misaligned-access trap: define MEM_MISALIGN_TRAP_EN.
module memory_access (
  input  logic clk,
  input  logic reset_n,
  memory_access_if.slave bus
);
  typedef enum logic {IDLE, BUSY} state_e;

  state_e      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_dest_q, wb_dest_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        misalign_q, misalign_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  f3_q, f3_d;
  logic        ld_q, ld_d;

  logic        is_mem;
  logic [1:0]  off;
  logic        mis;
  logic [3:0]  st_strb;
  logic [31:0] st_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_fmt;

  assign is_mem = bus.is_load | bus.is_store;
  assign off    = bus.addr_result[1:0];

`ifdef MEM_MISALIGN_TRAP_EN
  logic hw, wd;
  always_comb begin
    hw = bus.is_load ? (bus.func3[1:0] == 2'b01)
                     : (bus.func3 == 3'b001);
    wd = bus.is_load ? bus.func3[1]
                     : (bus.func3[2:1] != 2'b00);
    mis = (hw & off[0]) | (wd & (off != 2'b00));
  end
`else
  assign mis = 1'b0;
`endif

  always_comb begin
    st_strb = 4'b1111;
    st_data = bus.store_data;
    unique case (1'b1)
      bus.func3 == 3'b000: begin
        st_strb = 4'b0001 << off;
        st_data = {4{bus.store_data[7:0]}};
      end
      bus.func3 == 3'b001: begin
        st_strb = off[1] ? 4'b1100 : 4'b0011;
        st_data = {2{bus.store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = 8'(bus.mem_rdata >> {off_q, 3'b000});
    ld_half = off_q[1] ? bus.mem_rdata[31:16]
                       : bus.mem_rdata[15:0];
    ld_fmt  = bus.mem_rdata;
    unique case (1'b1)
      f3_q[1]: ld_fmt = bus.mem_rdata;
      ~f3_q[1] & f3_q[0]:
        ld_fmt = {{16{~f3_q[2] & ld_half[15]}}, ld_half};
      default:
        ld_fmt = {{24{~f3_q[2] & ld_byte[7]}}, ld_byte};
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      wb_valid_q  <= 1'b0;
      wb_dest_q   <= '0;
      wb_data_q   <= '0;
      misalign_q  <= 1'b0;
      off_q       <= '0;
      f3_q        <= '0;
      ld_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      wb_valid_q  <= wb_valid_d;
      wb_dest_q   <= wb_dest_d;
      wb_data_q   <= wb_data_d;
      misalign_q  <= misalign_d;
      off_q       <= off_d;
      f3_q        <= f3_d;
      ld_q        <= ld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.in_valid & is_mem & ~mis) state_d = BUSY;
      BUSY: if (bus.mem_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    wb_valid_d  = 1'b0;
    wb_dest_d   = wb_dest_q;
    wb_data_d   = wb_data_q;
    misalign_d  = 1'b0;
    off_d       = off_q;
    f3_d        = f3_q;
    ld_d        = ld_q;
    unique case (state_q)
      IDLE: if (bus.in_valid) begin
        if (!is_mem) begin
          wb_valid_d = 1'b1;
          wb_data_d  = bus.addr_result;
          wb_dest_d  = bus.dest_i;
        end else if (mis) begin
          misalign_d = 1'b1;
        end else begin
          mem_req_d   = 1'b1;
          mem_we_d    = ~bus.is_load;
          mem_addr_d  = {bus.addr_result[31:2], 2'b00};
          mem_wdata_d = st_data;
          mem_wstrb_d = st_strb;
          wb_dest_d   = bus.dest_i;
          off_d       = off;
          f3_d        = bus.func3;
          ld_d        = bus.is_load;
        end
      end
      BUSY: if (bus.mem_ready) begin
        mem_req_d = 1'b0;
        if (ld_q) begin
          wb_valid_d = 1'b1;
          wb_data_d  = ld_fmt;
        end
      end
      default: ;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wstrb = mem_wstrb_q;
  assign bus.wb_valid  = wb_valid_q;
  assign bus.wb_dest   = wb_dest_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.misalign  = misalign_q;
endmodule

// File: tb/tb_memory_access.sv
// Directed plus randomized bench for memory_access with a reference model.
module tb_memory_access;
  logic clk;
  logic reset_n;
  int   vectors = 0;
  int   miscompares = 0;

  memory_access_if bus();

  memory_access dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int acc_size(input bit ld, input logic [2:0] f3);
    if (ld) begin
      if (f3 == 3'd0 || f3 == 3'd4) return 1;
      if (f3 == 3'd1 || f3 == 3'd5) return 2;
      return 4;
    end
    if (f3 == 3'd0) return 1;
    if (f3 == 3'd1) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3,
      input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    int n;
    n = acc_size(1'b1, f3);
    if (n == 4) return rd;
    if (n == 1) begin
      v = (rd >> (int'(a[1:0]) * 8)) & 32'hFF;
      if (f3 == 3'd0 && v >= 128) v = v - 32'd256;
    end else begin
      v = (rd >> (int'(a[1]) * 16)) & 32'hFFFF;
      if (f3 == 3'd1 && v >= 32768) v = v - 32'd65536;
    end
    return v;
  endfunction

  function automatic logic [3:0] exp_strb(input logic [2:0] f3,
      input logic [31:0] a);
    int n;
    n = acc_size(1'b0, f3);
    if (n == 1) return 4'(1 << a[1:0]);
    if (n == 2) return a[1] ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3,
      input logic [31:0] sd);
    int n;
    n = acc_size(1'b0, f3);
    if (n == 1) return (sd & 32'hFF) * 32'h0101_0101;
    if (n == 2) return (sd & 32'hFFFF) * 32'h0001_0001;
    return sd;
  endfunction

  task automatic idle_inputs();
    bus.in_valid = 1'b0;
    bus.is_load  = 1'b0;
    bus.is_store = 1'b0;
  endtask

  task automatic alu_burst(input int n, input bit rnd,
                           input logic [31:0] a, input logic [4:0] d);
    logic [31:0] qa[$];
    logic [4:0]  qd[$];
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk("alu_wb_valid", bus.wb_valid, 1);
        chk("alu_wb_data", bus.wb_data, qa.pop_front());
        chk("alu_wb_dest", bus.wb_dest, qd.pop_front());
        chk("alu_in_ready", bus.in_ready, 1);
      end
      if (i < n) begin
        bus.in_valid = 1'b1;
        bus.is_load = 1'b0;
        bus.is_store = 1'b0;
        bus.func3 = 3'($urandom);
        bus.addr_result = rnd ? $urandom : a;
        bus.dest_i = rnd ? 5'($urandom) : d;
        qa.push_back(bus.addr_result);
        qd.push_back(bus.dest_i);
      end else begin
        idle_inputs();
      end
    end
    @(negedge clk);
    chk("alu_wb_pulse_end", bus.wb_valid, 0);
  endtask

  task automatic mem_op(input bit ld, input bit st, input logic [2:0] f3,
      input logic [31:0] a, input logic [31:0] sd, input logic [4:0] d,
      input int w, input logic [31:0] rd);
    bit eff_ld;
    bit mis;
    eff_ld = ld;
    mis = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    mis = (a % acc_size(ld, f3)) != 0;
`endif
    @(negedge clk);
    chk("pre_in_ready", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.is_load = ld;
    bus.is_store = st;
    bus.func3 = f3;
    bus.addr_result = a;
    bus.store_data = sd;
    bus.dest_i = d;
    @(negedge clk);
    idle_inputs();
    bus.addr_result = $urandom;
    bus.store_data = $urandom;
    if (mis) begin
      chk("mis_pulse", bus.misalign, 1);
      chk("mis_no_req", bus.mem_req, 0);
      chk("mis_no_wb", bus.wb_valid, 0);
      chk("mis_in_ready", bus.in_ready, 1);
      @(negedge clk);
      chk("mis_pulse_end", bus.misalign, 0);
      chk("mis_no_req2", bus.mem_req, 0);
      return;
    end
    for (int i = 0; i <= w; i++) begin
      chk("busy_req", bus.mem_req, 1);
      chk("busy_in_ready", bus.in_ready, 0);
      chk("busy_addr", bus.mem_addr, a & 32'hFFFF_FFFC);
      chk("busy_we", bus.mem_we, !eff_ld);
      chk("busy_wb_valid", bus.wb_valid, 0);
      chk("misalign_low", bus.misalign, 0);
      if (!eff_ld) begin
        chk("busy_wstrb", bus.mem_wstrb, exp_strb(f3, a));
        chk("busy_wdata", bus.mem_wdata, exp_wdata(f3, sd));
      end
      bus.mem_ready = (i == w);
      bus.mem_rdata = (i == w) ? rd : $urandom;
      @(negedge clk);
    end
    bus.mem_ready = 1'b0;
    bus.mem_rdata = $urandom;
    chk("done_req", bus.mem_req, 0);
    chk("done_in_ready", bus.in_ready, 1);
    chk("done_wb_valid", bus.wb_valid, eff_ld);
    if (eff_ld) begin
      chk("ld_wb_data", bus.wb_data, exp_load(f3, a, rd));
      chk("ld_wb_dest", bus.wb_dest, d);
    end
    @(negedge clk);
    chk("wb_pulse_end", bus.wb_valid, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    bus.func3 = 3'd0;
    bus.addr_result = '0;
    bus.store_data = '0;
    bus.dest_i = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_mem_wstrb", bus.mem_wstrb, 0);
    chk("rst_wb_valid", bus.wb_valid, 0);
    chk("rst_wb_dest", bus.wb_dest, 0);
    chk("rst_wb_data", bus.wb_data, 0);
    chk("rst_misalign", bus.misalign, 0);
    reset_n = 1'b1;

    alu_burst(3, 1'b0, 32'h1234_5678, 5'd5);
    mem_op(1, 0, 3'b000, 32'h103, 0, 5'd7, 0, 32'h80FF_0000);
    mem_op(1, 0, 3'b100, 32'h103, 0, 5'd8, 0, 32'h80FF_0000);
    mem_op(0, 1, 3'b001, 32'h202, 32'hABCD_1234, 5'd9, 0, 0);
    mem_op(1, 0, 3'b010, 32'h400, 0, 5'd10, 3, 32'hDEAD_BEEF);
    mem_op(1, 0, 3'b010, 32'h101, 0, 5'd11, 0, 32'hCAFE_F00D);
    mem_op(1, 1, 3'b001, 32'h106, 32'h5555_AAAA, 5'd0, 1, 32'h8001_7FFF);

    @(negedge clk);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    chk("idle_ready_no_wb", bus.wb_valid, 0);
    chk("idle_ready_no_req", bus.mem_req, 0);

    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.is_load = 1'b1;
    bus.func3 = 3'b010;
    bus.addr_result = 32'h300;
    bus.dest_i = 5'd3;
    @(negedge clk);
    idle_inputs();
    chk("rstmid_req_before", bus.mem_req, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rstmid_req_drop", bus.mem_req, 0);
    chk("rstmid_in_ready", bus.in_ready, 1);
    chk("rstmid_addr", bus.mem_addr, 0);
    @(negedge clk);
    reset_n = 1'b1;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h1111_2222;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    chk("rstmid_late_ready", bus.wb_valid, 0);
    chk("rstmid_in_ready2", bus.in_ready, 1);

    for (int k = 0; k < 60; k++) begin
      int kind;
      kind = $urandom_range(0, 2);
      if (kind == 0)
        alu_burst($urandom_range(1, 3), 1'b1, 0, 0);
      else
        mem_op(kind == 1, kind == 2, 3'($urandom), $urandom,
               $urandom, 5'($urandom), $urandom_range(0, 2), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
